// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - control FSM for a W-bit shift-add multiplier
// Sequences load, conditional add and shift strobes; the datapath lives outside.
module mul_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          q0,
  output logic          ld_m,
  output logic          ld_q,
  output logic          clr_a,
  output logic          ld_a,
  output logic          sh_r,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_m    = 1'b0;
    ld_q    = 1'b0;
    clr_a   = 1'b0;
    ld_a    = 1'b0;
    sh_r    = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        ld_m    = 1'b1;
        ld_q    = 1'b1;
        clr_a   = 1'b1;
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        ld_a    = q0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sh_r    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort squashes this cycle's strobes so the datapath is left untouched.
    if (abort && state_q != S_IDLE) begin
      ld_m    = 1'b0;
      ld_q    = 1'b0;
      clr_a   = 1'b0;
      ld_a    = 1'b0;
      sh_r    = 1'b0;
      done    = 1'b0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
// Phase-counting reference model plus a behavioural multiplier datapath.
module tb_mul_seq_ctrl;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int LAT = 2 * W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic q0;
  logic ld_m, ld_q, clr_a, ld_a, sh_r, busy, done;
  logic [CW-1:0] cnt;

  mul_seq_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .ld_a(ld_a), .sh_r(sh_r),
    .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural datapath driven by the DUT strobes.
  logic [W-1:0] m_in = '0, q_in = '0;
  logic [W-1:0] reg_m = '0, reg_q = '0, reg_a = '0, m_cap = '0, q_cap = '0;
  logic         reg_c = 1'b0;
  assign q0 = reg_q[0];

  always @(posedge clk) begin
    if (ld_m) begin reg_m <= m_in; m_cap <= m_in; end
    if (ld_q) begin reg_q <= q_in; q_cap <= q_in; end
    if (clr_a) {reg_c, reg_a} <= '0;
    if (ld_a) {reg_c, reg_a} <= {1'b0, reg_a} + {1'b0, reg_m};
    if (sh_r) {reg_c, reg_a, reg_q} <= {1'b0, reg_c, reg_a, reg_q} >> 1;
  end

  // Reference model: m_ph is the cycle number within an operation (0 = idle).
  int  m_ph    = 0;
  int  m_cnt   = 0;
  bit  m_known = 1'b0;

  function automatic int cnt_of(input int ph);
    if (ph <= 2) return 0;
    if (ph >= LAT) return W;
    return (ph - 2) / 2;
  endfunction

  always @(negedge clk) begin
    logic [6:0] e_out;
    logic [2*W-1:0] prod_exp;
    if (m_known) begin
      e_out = '0;
      e_out[1] = (m_ph != 0);
      if (m_ph != 0 && !abort) begin
        if (m_ph == 1)                e_out[6:4] = 3'b111;
        else if (m_ph == LAT)         e_out[0] = 1'b1;
        else if ((m_ph % 2) == 0)     e_out[3] = q0;
        else                          e_out[2] = 1'b1;
      end
      check("outputs{ldm,ldq,clra,lda,shr,busy,done}",
            {25'd0, ld_m, ld_q, clr_a, ld_a, sh_r, busy, done}, {25'd0, e_out});
      check("cnt", {28'd0, cnt}, m_cnt);
      if (done) begin
        prod_exp = {{W{1'b0}}, m_cap} * {{W{1'b0}}, q_cap};
        check("product", {16'd0, reg_a, reg_q}, {16'd0, prod_exp});
      end
    end
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_known = 1'b1;
    end else if (m_ph != 0 && abort) begin
      m_ph = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      if (start && !abort) begin m_ph = 1; m_cnt = 0; end
    end else if (m_ph == LAT) begin
      m_ph = 0;
    end else begin
      m_ph++;
      m_cnt = cnt_of(m_ph);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and observes one operation from cycle 1 for ncyc cycles.
  task automatic run_op(input logic [W-1:0] mv, input logic [W-1:0] qv, input int ncyc,
                        output int done_cyc, output int n_sh, output int n_lda,
                        output logic [W-1:0] lda_mask, output logic [2*W-1:0] prod);
    m_in = mv; q_in = qv;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = 0; n_sh = 0; n_lda = 0; lda_mask = '0; prod = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (ld_a) begin lda_mask[n_sh] = 1'b1; n_lda++; end
      if (sh_r) n_sh++;
      if (done && done_cyc == 0) begin done_cyc = c; prod = {reg_a, reg_q}; end
      tick();
    end
  endtask

  initial begin
    int dc, ns, nl, nd, last_d;
    logic [W-1:0] mask;
    logic [2*W-1:0] pr;
    bit found;

    rst = 1'b1;
    tick(); tick();
    check("reset_outputs", {ld_m, ld_q, clr_a, ld_a, sh_r, busy, done, cnt}, 0);
    rst = 1'b0;
    tick();

    // Worked example: 0x0D * 0xA5 = 0x0861
    run_op(8'h0D, 8'hA5, 20, dc, ns, nl, mask, pr);
    check("ex_done_cycle", dc, 18);
    check("ex_sh_r_count", ns, 8);
    check("ex_ld_a_count", nl, 4);
    check("ex_ld_a_bits", mask, 8'hA5);
    check("ex_product", pr, 16'h0861);

    // Start pulse at cycle 5 is ignored
    m_in = 8'h37; q_in = 8'h5C;
    start = 1'b1; tick(); start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 25; c++) begin
      start = (c == 5);
      if (done) nd++;
      tick();
    end
    start = 1'b0;
    check("restart_done_count", nd, 1);
    check("restart_cnt_after", cnt, 8);
    check("restart_idle", busy, 0);

    // Abort in the SHIFT cycle with cnt=3
    m_in = 8'hFF; q_in = 8'hFF;
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      if (sh_r && cnt == 4'd3) begin
        found = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt", cnt, 0);
      end else begin
        tick();
      end
    end
    check("abort_point_reached", found, 1);
    tick();
    run_op(8'hC3, 8'h81, 20, dc, ns, nl, mask, pr);
    check("after_abort_done_cycle", dc, 18);
    check("after_abort_product", pr, 16'h6243);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {busy, ld_m}, 0);

    // Reset during a CHECK cycle
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("in_check_cycle4", {busy, sh_r, cnt}, {1'b1, 1'b0, 4'd1});
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_outputs", {ld_m, ld_q, clr_a, ld_a, sh_r, busy, done, cnt}, 0);

    // Held start with Q=0
    m_in = 8'($urandom); q_in = 8'h00;
    start = 1'b1; tick();
    nd = 0; nl = 0; last_d = 0;
    for (int c = 1; c <= 80; c++) begin
      if (ld_a) nl++;
      if (done) begin
        if (nd == 0) check("held_first_done", c, 18);
        else         check("held_period", c - last_d, 19);
        nd++;
        last_d = c;
      end
      tick();
    end
    start = 1'b0;
    check("held_done_count", nd, 4);
    check("held_ld_a_count", nl, 0);
    repeat (20) tick();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      m_in  = 8'($urandom);
      q_in  = 8'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: operand width, in bits, of the shift-add multiplier datapath.
REQ-002 SHALL have parameter CW, default 4: counter width, equal to ceil(log2(W+1)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-007 SHALL have port q0, input, 1 bit: current LSB of the multiplier shift register Q.
REQ-008 SHALL have port ld_m, output, 1 bit: load strobe for the multiplicand register M.
REQ-009 SHALL have port ld_q, output, 1 bit: load strobe for the multiplier register Q.
REQ-010 SHALL have port clr_a, output, 1 bit: clear strobe for the accumulator A.
REQ-011 SHALL have port ld_a, output, 1 bit: load strobe that writes A+M into A.
REQ-012 SHALL have port sh_r, output, 1 bit: right-shift strobe for the chained pair carry:A:Q.
REQ-013 SHALL have port busy, output, 1 bit: operation in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port cnt, output, CW bits: number of shifts completed in the current operation.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, LOAD, CHECK, SHIFT and DONE.
REQ-017 In IDLE, start=1 and abort=0 SHALL cause a transition to LOAD; otherwise the FSM SHALL remain in IDLE.
REQ-018 LOAD SHALL assert ld_m, ld_q and clr_a for exactly one cycle, set cnt to 0, and transition to CHECK.
REQ-019 CHECK SHALL drive ld_a equal to q0 (combinational from q0 in that cycle) and transition to SHIFT.
REQ-020 SHIFT SHALL assert sh_r for one cycle and increment cnt.
REQ-021 From SHIFT, the FSM SHALL go to DONE if cnt==W-1 before the increment, and to CHECK otherwise.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 busy SHALL be 1 in LOAD, CHECK, SHIFT and DONE, and 0 in IDLE.
REQ-024 Latency SHALL be fixed: with start sampled at edge E0, LOAD occupies cycle 1, CHECK/SHIFT occupy cycles 2..2W+1, and done=1 during cycle 2W+2 (cycle 18 for W=8).
REQ-025 Exactly W sh_r pulses and at most W ld_a pulses SHALL occur per completed operation.
REQ-026 ld_a and sh_r SHALL never be asserted in the same cycle.
REQ-027 ld_m, ld_q and clr_a SHALL be asserted only in LOAD.
REQ-028 start while busy=1, including during DONE, SHALL be ignored with no queuing.
REQ-029 A held start SHALL be re-accepted only from IDLE, so back-to-back operations are separated by at least one IDLE cycle and the start-to-start period is 2W+3 cycles.
REQ-030 abort=1 in any non-IDLE state SHALL force all strobes and done to 0 in that cycle and move the FSM to IDLE at the next edge, with cnt cleared and no done pulse.
REQ-031 start=1 together with abort=1 in IDLE SHALL leave the FSM in IDLE.
REQ-032 cnt SHALL hold its value in IDLE until the next LOAD and SHALL never exceed W.

Reset
REQ-033 rst=1 at a posedge SHALL force IDLE, cnt=0 and all strobes, busy and done to 0, overriding start and abort.
REQ-034 rst asserted mid-operation SHALL take effect at the next edge with no done pulse.
REQ-035 All outputs SHALL be 0 in the cycle after any reset edge.

Verification
REQ-036 Reset: hold rst=1 for 2 cycles -> busy=0, done=0, ld_m/ld_q/clr_a/ld_a/sh_r=0, cnt=0.
REQ-037 W=8, bench datapath model with M=8'h0D and Q=8'hA5 -> ld_a high in CHECK for bits 0,2,5,7 only; 8 sh_r pulses; done in cycle 18; {A,Q}=16'h0861.
REQ-038 Pulse start again at cycle 5 of an operation -> ignored; exactly one done; cnt=8 after DONE.
REQ-039 abort in the SHIFT cycle where cnt=3 -> next cycle IDLE, busy=0, no done; a following start completes normally in 18 cycles.
REQ-040 start=abort=1 in IDLE -> remains IDLE; separately, rst during a CHECK cycle -> IDLE next cycle with all strobes 0.
REQ-041 start held high with Q=8'h00 -> no ld_a pulses; done pulses every 19 cycles.
